// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the multi-port register file.
//   clrState_t  : states of the sequential clear engine
//   sweepStart  : first register index touched by a clear sweep
package regfile_mp_sb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clrState_t;

  // With a hardwired-zero R0 there is nothing to clear at index 0,
  // so the sweep starts one register later.
  function automatic int sweepStart(input int zeroR0);
    return (zeroR0 != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy scoreboard used for hazard detection.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clearAll   : zero every busy bit (start of a clear sweep), wins over everything
//   setEn/Addr : reserve a destination register (mark busy)
//   clrVec     : one bit per register, set when a write lands on that register
//   rdAddr     : packed read-port addresses
//   rdBypass   : per read port, a same-cycle write is being forwarded to it
//   rdBusy     : per read port busy lookup, suppressed when the value is forwarded
module regfile_mp_sb_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int AW       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clearAll,
  input  logic                 setEn,
  input  logic [AW-1:0]        setAddr,
  input  logic [NUM_REGS-1:0]  clrVec,
  input  logic [NUM_RD*AW-1:0] rdAddr,
  input  logic [NUM_RD-1:0]    rdBypass,
  output logic [NUM_RD-1:0]    rdBusy
);

  logic [NUM_REGS-1:0] busy;

  // A reservation beats a write to the same register in the same cycle:
  // the newly issued instruction is the producer that is still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (clearAll) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (setEn && (setAddr == AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (clrVec[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gLookup
    assign rdBusy[i] = busy[rdAddr[i*AW +: AW]] & ~rdBypass[i];
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file for the decode stage of the pipelined CPU.
// Combinational reads with same-cycle write bypass, optional hardwired
// zero R0, a busy scoreboard and a sequential clear engine.
// Ports:
//   clk, rst_n         : clock and asynchronous active-low reset
//   rd_addr/rd_data    : NUM_RD packed read ports, 0-cycle latency
//   rd_busy            : scoreboard busy bit of each addressed register
//   wr_en/addr/data    : NUM_WR packed write ports, highest index wins on conflict
//   rsv_en/rsv_addr    : mark a destination register busy
//   clr_req            : start a clear sweep (only honoured in IDLE)
//   clr_busy/clr_done  : sweep in progress / one-cycle completion pulse
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 16,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_R0  = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  clrState_t           state, nextState;
  logic [AW-1:0]       cnt, nextCnt;
  logic                clearing;
  logic                sweepEntry;
  logic [NUM_WR-1:0]   wrEnEff;
  logic                rsvEnEff;
  logic [NUM_REGS-1:0] wrClrVec;
  logic [NUM_RD-1:0]   rdHit;

  assign clearing   = (state == CLEAR);
  assign sweepEntry = (state == IDLE) && clr_req;
  assign clr_busy   = clearing;
  assign clr_done   = (state == DONE);

  // External writes and reservations are silently dropped while sweeping;
  // R0 writes/reservations vanish when R0 is hardwired to zero. Gating here
  // means bypass and scoreboard never see a write that will not land.
  for (genvar j = 0; j < NUM_WR; j++) begin : gWrEn
    assign wrEnEff[j] = wr_en[j] & ~clearing &
                        ~((ZERO_R0 != 0) && (wr_addr[j*AW +: AW] == '0));
  end

  assign rsvEnEff = rsv_en & ~clearing & ~((ZERO_R0 != 0) && (rsv_addr == '0));

  // Clear engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // The counter stops at NUM_REGS-1, so it never needs to wrap.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          nextState = CLEAR;
          nextCnt   = AW'(sweepStart(ZERO_R0));
        end
      end
      CLEAR: begin
        nextCnt = cnt + AW'(1);
        if (cnt == AW'(NUM_REGS - 1)) begin
          nextState = DONE;
          nextCnt   = '0;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Storage. Later ports overwrite earlier ones in the loop, giving the
  // highest-index port priority on an address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (clearing) begin
      regs[cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wrEnEff[j]) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Registers receiving a write this cycle, for busy-bit release.
  always_comb begin
    wrClrVec = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wrEnEff[j]) begin
        wrClrVec[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  // Read muxes: stored value, overridden by the highest matching write
  // port, overridden again by the hardwired zero.
  for (genvar i = 0; i < NUM_RD; i++) begin : gRead
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic              hit;

    assign addr = rd_addr[i*AW +: AW];

    always_comb begin
      data = regs[addr];
      hit  = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if ((BYPASS != 0) && wrEnEff[j] && (wr_addr[j*AW +: AW] == addr)) begin
          data = wr_data[j*DATA_W +: DATA_W];
          hit  = 1'b1;
        end
      end
      if ((ZERO_R0 != 0) && (addr == '0)) begin
        data = '0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rdHit[i] = hit;
  end

  regfile_mp_sb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .AW       (AW)
  ) uScoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clearAll (sweepEntry),
    .setEn    (rsvEnEff),
    .setAddr  (rsv_addr),
    .clrVec   (wrClrVec),
    .rdAddr   (rd_addr),
    .rdBypass (rdHit),
    .rdBusy   (rd_busy)
  );

endmodule
